// File: rtl/expmu_table_buffer.sv
// Ping-pong table buffer for the S0*exp(t*mu) drift generator. A new table is
// filled into the back bank and swapped to the front after a complete fill.
module expmu_table_buffer #(
  parameter int DEPTH   = 64,
  parameter int logT    = 6,
  parameter int DW      = 17,
  parameter int TIMEOUT = 1024
) (
  input  logic            CLK,
  input  logic            iRstN,
  input  logic            iLoad,
  output logic            oStart,
  input  logic [DW-1:0]   iData,
  input  logic [logT-1:0] iAddr,
  input  logic            iValid,
  input  logic            iDone,
  input  logic            iRdEn,
  input  logic [logT-1:0] iRdAddr,
  output logic [DW-1:0]   oRdData,
  output logic            oRdValid,
  output logic            oReady,
  output logic            oBusy,
  output logic            oErr,
  output logic [7:0]      oSeq
);

  // One extra bit so the beat counter can saturate at DEPTH+1.
  localparam int CW = logT + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEPTH + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, FILL, SWAP} state_t;

  state_t          state;
  state_t          state_next;
  logic            bank_sel;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   beats;
  logic [TW-1:0]   to_cnt;
  logic            done_ok;
  logic            timed_out;
  logic            fill_abort;
  logic            ready;
  logic            err;
  logic [7:0]      seq;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic [DW-1:0]   mem [2*DEPTH];

  // A beat arriving together with iDone still counts toward completion.
  always_comb begin
    beats      = wr_cnt + CW'(iValid);
    done_ok    = (beats == CNT_FULL);
    timed_out  = (to_cnt == TO_LAST);
    fill_abort = iDone ? !done_ok : timed_out;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (iLoad) state_next = START;
      START: state_next = FILL;
      FILL: begin
        if (iDone && done_ok) state_next = SWAP;
        else if (fill_abort)  state_next = IDLE;
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      state    <= IDLE;
      bank_sel <= 1'b0;
      wr_cnt   <= '0;
      to_cnt   <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      seq      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (iLoad) begin
            err    <= 1'b0;
            wr_cnt <= '0;
            to_cnt <= '0;
          end
        end
        FILL: begin
          if (iValid && wr_cnt != CNT_SAT) wr_cnt <= wr_cnt + 1'b1;
          to_cnt <= to_cnt + 1'b1;
          if (fill_abort) err <= 1'b1;
        end
        SWAP: begin
          bank_sel <= ~bank_sel;
          ready    <= 1'b1;
          seq      <= seq + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Writes only ever target the back bank, so they cannot disturb readers.
  always_ff @(posedge CLK) begin
    if (state == FILL && iValid) mem[{~bank_sel, iAddr}] <= iData;
  end

  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= iRdEn && ready;
      if (iRdEn) rd_data <= ready ? mem[{bank_sel, iRdAddr}] : '0;
    end
  end

  assign oStart   = (state == START);
  assign oBusy    = (state != IDLE);
  assign oReady   = ready;
  assign oErr     = err;
  assign oSeq     = seq;
  assign oRdData  = rd_data;
  assign oRdValid = rd_valid;

endmodule
